// File: rtl/uart_fabric_tx.sv
// 8N1 UART transmitter with a transmit FIFO and CTS flow control.
// A byte is only started while the synchronized clear-to-send input is low.
module uart_fabric_tx #(
   parameter int unsigned BAUD_DIV   = 434,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          cts_n,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(BAUD_DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          cts_meta;
   logic          cts_sync;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] baud_cnt;
   logic [CW-1:0] baud_cnt_nx;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_nx;
   logic [7:0]    shift;
   logic [7:0]    shift_nx;
   logic          txd_nx;

   assign in_ready = (fifo_level < LW'(FIFO_DEPTH));
   assign push     = in_valid && in_ready;
   assign busy     = (state != IDLE) || (fifo_level != '0);

   // FIFO storage needs no reset; the pointers and level define its contents
   always_ff @(posedge clk_clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Two-flop synchronizer; resets to "not clear to send"
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         cts_meta <= 1'b1;
         cts_sync <= 1'b1;
      end else begin
         cts_meta <= cts_n;
         cts_sync <= cts_meta;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         txd      <= 1'b1;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_cnt_nx;
         bit_idx  <= bit_idx_nx;
         shift    <= shift_nx;
         txd      <= txd_nx;
      end
   end

   // txd_nx is the line level for the next clock, so txd itself is a flop
   always_comb begin
      state_nx    = state;
      baud_cnt_nx = baud_cnt;
      bit_idx_nx  = bit_idx;
      shift_nx    = shift;
      txd_nx      = txd;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            txd_nx = 1'b1;
            if ((fifo_level != '0) && !cts_sync) begin
               pop         = 1'b1;
               shift_nx    = mem[rd_ptr];
               baud_cnt_nx = CW'(BAUD_DIV - 1);
               txd_nx      = 1'b0;
               state_nx    = START;
            end
         end
         START: begin
            if (baud_cnt == '0) begin
               baud_cnt_nx = CW'(BAUD_DIV - 1);
               bit_idx_nx  = '0;
               txd_nx      = shift[0];
               state_nx    = DATA;
            end else begin
               baud_cnt_nx = baud_cnt - CW'(1);
            end
         end
         DATA: begin
            if (baud_cnt == '0) begin
               baud_cnt_nx = CW'(BAUD_DIV - 1);
               if (bit_idx == 3'd7) begin
                  txd_nx   = 1'b1;
                  state_nx = STOP;
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
                  shift_nx   = {1'b0, shift[7:1]};
                  txd_nx     = shift[1];
               end
            end else begin
               baud_cnt_nx = baud_cnt - CW'(1);
            end
         end
         STOP: begin
            txd_nx = 1'b1;
            if (baud_cnt == '0) begin
               state_nx = IDLE;
            end else begin
               baud_cnt_nx = baud_cnt - CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            txd_nx   = 1'b1;
         end
      endcase
   end

endmodule
